// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard scan-code decoder: strips E0/F0 prefixes, queues {ext,break,code}
// events in a first-word-fall-through FIFO and tracks the Shift key state.
module ps2_kb_decoder #(
    parameter int W_SIZE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_key,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       shift_on,
    output logic       overflow
);

    localparam int DEPTH = 2 ** W_SIZE;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t state, state_next;
    logic   is_status, push_req, ev_ext, ev_brk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        is_status  = 1'b0;
        ev_ext     = (state == EXT) || (state == EXT_BRK);
        ev_brk     = (state == BRK) || (state == EXT_BRK);
        case (rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
            default:                                         is_status = 1'b0;
        endcase
        if (rx_done_tick) begin
            if (rx_data == 8'hE0) begin
                state_next = (state == IDLE || state == EXT) ? EXT : EXT_BRK;
            end else if (rx_data == 8'hF0) begin
                state_next = (state == IDLE || state == BRK) ? BRK : EXT_BRK;
            end else if (is_status) begin
                state_next = IDLE;
            end else begin
                push_req   = 1'b1;
                state_next = IDLE;
            end
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable
    logic [9:0]      mem [DEPTH];
    logic [W_SIZE:0] wr_ptr, rd_ptr;
    logic            empty, full, pop, push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[W_SIZE] != rd_ptr[W_SIZE]) &&
                   (wr_ptr[W_SIZE-1:0] == rd_ptr[W_SIZE-1:0]);
    assign pop   = rd_key && !empty;
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[W_SIZE-1:0]] <= {ev_ext, ev_brk, rx_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // Shift tracking follows the decoded event even when the FIFO drops it
    logic lshift, rshift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (push_req && !ev_ext) begin
            if (rx_data == 8'h12) lshift <= !ev_brk;
            if (rx_data == 8'h59) rshift <= !ev_brk;
        end
    end

    logic [9:0] head;

    assign head      = mem[rd_ptr[W_SIZE-1:0]];
    assign key_valid = !empty;
    assign key_ext   = key_valid ? head[9]   : 1'b0;
    assign key_break = key_valid ? head[8]   : 1'b0;
    assign key_code  = key_valid ? head[7:0] : 8'h00;
    assign shift_on  = lshift | rshift;

endmodule
